debug_cmd_sysclk_bridge: RTL and testbench
==========================================

Name: debug_cmd_sysclk_bridge

Overview:
- Parametrised sysclk-side command bridge for the CPU debug slave. It receives the virtual-JTAG update strobes (vs_udr, vs_uir), the IR code and the scan register, which are asynchronous to clk. It synchronises the strobes, captures each scan into a one-deep holding slot with a valid/ready handshake, and emits per-IR one-hot take_action / take_no_action pulses.
- It generalises the fixed 2-bit-IR / 38-bit-SR sysclk decoder with configurable widths, synchroniser depth and an action-select bit. It adds back-pressure, overrun detection and post-reset arming.

Parameters:
- SR_W, 38, scan register / jdo width.
- IR_W, 2, IR code width; NUM_CMD = 2**IR_W (localparam).
- SYNC_STAGES, 2, synchroniser flops per strobe (legal values 2..4).
- ACTION_BIT, 35, sr bit that selects take_action (1) or take_no_action (0); must be < SR_W.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- vs_udr  in  1  update-DR strobe, TCK domain, asynchronous; high for at least 1 TCK.
- vs_uir  in  1  update-IR strobe, TCK domain, asynchronous.
- ir_in  in  IR_W  current virtual IR code; quasi-static around vs_udr.
- sr  in  SR_W  scan register; stable from vs_udr rise until the next shift.
- cmd_ready  in  1  consumer accepts the held command.
- overrun_clr  in  1  clears overrun.
- jdo  out  SR_W  captured scan data.
- cmd_ir  out  IR_W  IR code captured with jdo.
- cmd_valid  out  1  holding slot occupied.
- take_action  out  NUM_CMD  one-hot, 1-cycle pulse, indexed by cmd_ir.
- take_no_action  out  NUM_CMD  one-hot, 1-cycle pulse, indexed by cmd_ir.
- uir_seen  out  1  1-cycle pulse on each synchronised vs_uir rise.
- overrun  out  1  sticky flag: an update was dropped.

Behaviour:
- Reset:
  - All synchroniser and edge flops clear to 0.
  - jdo, cmd_ir, cmd_valid, take_action, take_no_action, uir_seen and overrun are all 0.
  - Reset mid-operation discards the held command and any in-flight edge.
- Arming:
  - A counter loads SYNC_STAGES+1 on reset and decrements to 0 after reset deasserts.
  - Edges are ignored while the counter is nonzero, so a strobe that is already high at reset release is never reported as an edge.
  - Edge flops still track their inputs during arming.
- Synchronisation: each strobe passes through a SYNC_STAGES flop chain, then one edge flop. rise = sync_out & ~edge_q.
- Latency: cmd_valid and the decode pulse assert on clock edge SYNC_STAGES+1, counting the first clk edge that samples vs_udr high as edge 1.
- Capture on udr rise, when armed, and when the slot is free (cmd_valid==0, or cmd_valid & cmd_ready in the same cycle):
  - jdo<=sr, cmd_ir<=ir_in, cmd_valid<=1.
  - In the same cycle, take_action[ir_in] pulses if sr[ACTION_BIT]==1; otherwise take_no_action[ir_in] pulses.
  - Exactly one bit of the two vectors is high for one cycle. Both vectors are 0 in all other cycles.
- Handshake:
  - cmd_valid holds with jdo and cmd_ir stable until a cycle with cmd_ready==1; cmd_valid then clears on the next edge.
  - If a capture happens in the same cycle as consumption, the slot reloads and cmd_valid stays 1.
- Overrun:
  - A udr rise while cmd_valid & ~cmd_ready drops the new update: jdo is unchanged and no pulse is emitted.
  - overrun<=1 in that case.
  - overrun_clr clears overrun. If set and clear coincide, set wins.
- uir:
  - A rise (when armed) pulses uir_seen for one cycle.
  - It does not touch the slot, cmd_valid or overrun.
  - Simultaneous uir and udr rises are handled independently.
- Widths: sr and jdo are SR_W bits; ir_in indexes take_action directly with no truncation. take_action has bit width NUM_CMD.

Decomposition:
- Package debug_bridge_pkg holds:
  - the default constants SR_W_DEF=38, IR_W_DEF=2 and ACTION_BIT_DEF=35;
  - the IR code constants IR_OCIMEM=0, IR_TRACE=1, IR_BREAK=2 and IR_TRACECTRL=3.
- One sub-module, debug_strobe_sync:
  - parametrised by SYNC_STAGES;
  - inputs clk, reset, async_in and armed; output rise_pulse.
  - It is instantiated twice, for udr and uir.

Test Plan:
- Reset release with vs_udr held high, then held for 10 cycles -> no cmd_valid and no pulses. The next genuine 0->1 edge is captured.
- SYNC_STAGES=2, sr=38'h2_0000_00AB (bit35=0), ir_in=2, single vs_udr pulse -> on edge 3: cmd_valid=1, jdo=38'h2_0000_00AB, cmd_ir=2, take_no_action=4'b0100 for 1 cycle, take_action=0.
- Repeat with sr bit35=1 and ir_in=0 -> take_action=4'b0001 for one cycle. cmd_ready=1 one cycle later -> cmd_valid=0 on the following edge.
- Hold cmd_ready=0 and send a second udr with sr=38'h5 -> jdo keeps its first value, no pulse, overrun=1. Assert overrun_clr and a third dropped udr in the same cycle -> overrun stays 1.
- Back-to-back: cmd_ready=1 in the same cycle as the next capture -> cmd_valid stays 1, jdo updates to the new sr, exactly one pulse.
- vs_uir pulse coincident with vs_udr -> uir_seen and take_* pulse in the same cycle. Assert reset while cmd_valid=1 -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/debug_bridge_pkg.sv
// Shared constants for the debug command bridge: default widths and the
// virtual-IR command codes decoded on the sysclk side.
package debug_bridge_pkg;

  localparam int SR_W_DEF       = 38;
  localparam int IR_W_DEF       = 2;
  localparam int ACTION_BIT_DEF = 35;

  localparam int IR_OCIMEM    = 0;
  localparam int IR_TRACE     = 1;
  localparam int IR_BREAK     = 2;
  localparam int IR_TRACECTRL = 3;

endpackage

// File: rtl/debug_strobe_sync.sv
// Brings one asynchronous TCK-domain strobe into clk and reports its rising
// edge as a single-cycle pulse, suppressed while the bridge is not yet armed.
module debug_strobe_sync
  import debug_bridge_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  input  logic armed,
  output logic rise_pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;

  // The edge flop keeps following the synchroniser while unarmed, so a level
  // already high at reset release never looks like a fresh edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      edge_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_pulse = sync_q[SYNC_STAGES-1] & ~edge_q & armed;

endmodule

// File: rtl/debug_cmd_sysclk_bridge.sv
// Sysclk-side command bridge for the CPU debug slave: captures each update-DR
// scan into a one-deep slot with valid/ready and decodes per-IR action pulses.
module debug_cmd_sysclk_bridge
  import debug_bridge_pkg::*;
#(
  parameter int SR_W        = SR_W_DEF,
  parameter int IR_W        = IR_W_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int ACTION_BIT  = ACTION_BIT_DEF,
  localparam int NUM_CMD    = 2 ** IR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               vs_udr,
  input  logic               vs_uir,
  input  logic [IR_W-1:0]    ir_in,
  input  logic [SR_W-1:0]    sr,
  input  logic               cmd_ready,
  input  logic               overrun_clr,
  output logic [SR_W-1:0]    jdo,
  output logic [IR_W-1:0]    cmd_ir,
  output logic               cmd_valid,
  output logic [NUM_CMD-1:0] take_action,
  output logic [NUM_CMD-1:0] take_no_action,
  output logic               uir_seen,
  output logic               overrun
);

  localparam int ARM_W = $clog2(SYNC_STAGES + 2);

  logic [ARM_W-1:0]   arm_cnt_q, arm_cnt_d;
  logic               armed;
  logic               udr_rise, uir_rise;
  logic               slot_free, capture, drop;

  logic [SR_W-1:0]    jdo_q, jdo_d;
  logic [IR_W-1:0]    cmd_ir_q, cmd_ir_d;
  logic               cmd_valid_q, cmd_valid_d;
  logic [NUM_CMD-1:0] take_action_q, take_action_d;
  logic [NUM_CMD-1:0] take_no_action_q, take_no_action_d;
  logic               uir_seen_q;
  logic               overrun_q, overrun_d;

  assign armed = (arm_cnt_q == '0);

  debug_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_udr_sync (
    .clk       (clk),
    .reset     (reset),
    .async_in  (vs_udr),
    .armed     (armed),
    .rise_pulse(udr_rise)
  );

  debug_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_uir_sync (
    .clk       (clk),
    .reset     (reset),
    .async_in  (vs_uir),
    .armed     (armed),
    .rise_pulse(uir_rise)
  );

  always_comb begin
    arm_cnt_d        = (arm_cnt_q != '0) ? arm_cnt_q - 1'b1 : arm_cnt_q;
    slot_free        = ~cmd_valid_q | cmd_ready;
    capture          = udr_rise & slot_free;
    drop             = udr_rise & ~slot_free;
    jdo_d            = jdo_q;
    cmd_ir_d         = cmd_ir_q;
    cmd_valid_d      = cmd_valid_q & ~cmd_ready;
    take_action_d    = '0;
    take_no_action_d = '0;
    // A capture in the same cycle as consumption simply reloads the slot.
    if (capture) begin
      jdo_d       = sr;
      cmd_ir_d    = ir_in;
      cmd_valid_d = 1'b1;
      if (sr[ACTION_BIT]) take_action_d[ir_in]    = 1'b1;
      else                take_no_action_d[ir_in] = 1'b1;
    end
    // A dropped update outranks a simultaneous clear.
    if (drop)             overrun_d = 1'b1;
    else if (overrun_clr) overrun_d = 1'b0;
    else                  overrun_d = overrun_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      arm_cnt_q        <= ARM_W'(SYNC_STAGES + 1);
      jdo_q            <= '0;
      cmd_ir_q         <= '0;
      cmd_valid_q      <= 1'b0;
      take_action_q    <= '0;
      take_no_action_q <= '0;
      uir_seen_q       <= 1'b0;
      overrun_q        <= 1'b0;
    end else begin
      arm_cnt_q        <= arm_cnt_d;
      jdo_q            <= jdo_d;
      cmd_ir_q         <= cmd_ir_d;
      cmd_valid_q      <= cmd_valid_d;
      take_action_q    <= take_action_d;
      take_no_action_q <= take_no_action_d;
      uir_seen_q       <= uir_rise;
      overrun_q        <= overrun_d;
    end
  end

  assign jdo            = jdo_q;
  assign cmd_ir         = cmd_ir_q;
  assign cmd_valid      = cmd_valid_q;
  assign take_action    = take_action_q;
  assign take_no_action = take_no_action_q;
  assign uir_seen       = uir_seen_q;
  assign overrun        = overrun_q;

endmodule

// File: tb/tb_debug_cmd_sysclk_bridge.sv
// Randomised and directed bench for debug_cmd_sysclk_bridge against a
// cycle-level behavioural model of the command slot.
module tb_debug_cmd_sysclk_bridge;

  localparam int SRW = 38;
  localparam int IRW = 2;
  localparam int NC  = 4;
  localparam int SS  = 2;
  localparam int AB  = 35;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           vs_udr = 1'b0;
  logic           vs_uir = 1'b0;
  logic [IRW-1:0] ir_in = '0;
  logic [SRW-1:0] sr = '0;
  logic           cmd_ready = 1'b0;
  logic           overrun_clr = 1'b0;
  logic [SRW-1:0] jdo;
  logic [IRW-1:0] cmd_ir;
  logic           cmd_valid;
  logic [NC-1:0]  take_action;
  logic [NC-1:0]  take_no_action;
  logic           uir_seen;
  logic           overrun;

  debug_cmd_sysclk_bridge #(
    .SR_W(SRW), .IR_W(IRW), .SYNC_STAGES(SS), .ACTION_BIT(AB)
  ) dut (
    .clk(clk), .reset(reset), .vs_udr(vs_udr), .vs_uir(vs_uir),
    .ir_in(ir_in), .sr(sr), .cmd_ready(cmd_ready), .overrun_clr(overrun_clr),
    .jdo(jdo), .cmd_ir(cmd_ir), .cmd_valid(cmd_valid),
    .take_action(take_action), .take_no_action(take_no_action),
    .uir_seen(uir_seen), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: strobe level history (index k = sample taken k edges ago)
  bit             hu [0:SS+1];
  bit             hi [0:SS+1];
  int             edges_since_rst = 0;
  logic [SRW-1:0] m_jdo = '0;
  logic [IRW-1:0] m_ir = '0;
  bit             m_valid = 0;
  logic [NC-1:0]  m_ta = '0;
  logic [NC-1:0]  m_tna = '0;
  bit             m_uir = 0;
  bit             m_ovr = 0;

  task automatic model_step();
    bit armed, uev, iev, drop;
    if (reset) begin
      for (int i = 0; i <= SS + 1; i++) begin hu[i] = 0; hi[i] = 0; end
      edges_since_rst = 0;
      m_jdo = '0; m_ir = '0; m_valid = 0; m_ta = '0; m_tna = '0; m_uir = 0; m_ovr = 0;
    end else begin
      if (edges_since_rst < 1000) edges_since_rst++;
      for (int i = SS + 1; i > 0; i--) begin hu[i] = hu[i-1]; hi[i] = hi[i-1]; end
      hu[0] = vs_udr;
      hi[0] = vs_uir;
      armed = (edges_since_rst >= SS + 2);
      uev = armed && hu[SS] && !hu[SS+1];
      iev = armed && hi[SS] && !hi[SS+1];
      drop = 0;
      m_ta = '0;
      m_tna = '0;
      m_uir = iev;
      if (uev && (!m_valid || cmd_ready)) begin
        m_jdo = sr;
        m_ir = ir_in;
        m_valid = 1;
        if (sr[AB]) m_ta = NC'(1) << ir_in;
        else        m_tna = NC'(1) << ir_in;
      end else if (uev) begin
        drop = 1;
      end else if (m_valid && cmd_ready) begin
        m_valid = 0;
      end
      if (drop)             m_ovr = 1;
      else if (overrun_clr) m_ovr = 0;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    chk("jdo", 64'(jdo), 64'(m_jdo));
    chk("cmd_ir", 64'(cmd_ir), 64'(m_ir));
    chk("cmd_valid", 64'(cmd_valid), 64'(m_valid));
    chk("take_action", 64'(take_action), 64'(m_ta));
    chk("take_no_action", 64'(take_no_action), 64'(m_tna));
    chk("uir_seen", 64'(uir_seen), 64'(m_uir));
    chk("overrun", 64'(overrun), 64'(m_ovr));
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  int low_cnt = 0;

  initial begin
    for (int i = 0; i <= SS + 1; i++) begin hu[i] = 0; hi[i] = 0; end

    // Strobe held high through reset release must not be reported
    reset = 1'b1; vs_udr = 1'b1; sr = 38'h0_1111_2222; ir_in = 2'd1;
    idle(3);
    chk("rst_valid", 64'(cmd_valid), 64'd0);
    reset = 1'b0;
    idle(10);
    chk("arm_valid", 64'(cmd_valid), 64'd0);
    chk("arm_ta", 64'(take_action), 64'd0);
    chk("arm_tna", 64'(take_no_action), 64'd0);
    vs_udr = 1'b0;
    idle(3);
    vs_udr = 1'b1; cycle(); vs_udr = 1'b0; idle(2);
    chk("arm_first_edge", 64'(cmd_valid), 64'd1);
    chk("arm_first_jdo", 64'(jdo), 64'h0_1111_2222);
    cmd_ready = 1'b1; cycle(); cmd_ready = 1'b0; idle(2);

    // Latency and no-action decode
    sr = 38'h2_0000_00AB; ir_in = 2'd2;
    vs_udr = 1'b1; cycle(); vs_udr = 1'b0; cycle();
    chk("lat_early", 64'(cmd_valid), 64'd0);
    cycle();
    chk("lat_valid", 64'(cmd_valid), 64'd1);
    chk("lat_jdo", 64'(jdo), 64'h2_0000_00AB);
    chk("lat_ir", 64'(cmd_ir), 64'd2);
    chk("lat_tna", 64'(take_no_action), 64'b0100);
    chk("lat_ta", 64'(take_action), 64'd0);
    cycle();
    chk("lat_tna_once", 64'(take_no_action), 64'd0);
    cmd_ready = 1'b1; cycle(); cmd_ready = 1'b0; idle(2);

    // Action decode, then consumption one cycle later
    sr = 38'h8_1234_5678; ir_in = 2'd0;
    vs_udr = 1'b1; cycle(); vs_udr = 1'b0; idle(2);
    chk("act_ta", 64'(take_action), 64'b0001);
    chk("act_tna", 64'(take_no_action), 64'd0);
    cmd_ready = 1'b1; cycle(); cmd_ready = 1'b0;
    chk("act_consumed", 64'(cmd_valid), 64'd0);
    idle(2);

    // Overrun: slot held, second update dropped
    sr = 38'h1_2345_6789; ir_in = 2'd1;
    vs_udr = 1'b1; cycle(); vs_udr = 1'b0; idle(4);
    sr = 38'h5; ir_in = 2'd3;
    vs_udr = 1'b1; cycle(); vs_udr = 1'b0; idle(2);
    chk("ovr_jdo_kept", 64'(jdo), 64'h1_2345_6789);
    chk("ovr_no_ta", 64'(take_action), 64'd0);
    chk("ovr_no_tna", 64'(take_no_action), 64'd0);
    chk("ovr_set", 64'(overrun), 64'd1);
    idle(2);
    sr = 38'h3F_0000_0000; ir_in = 2'd2;
    vs_udr = 1'b1; cycle(); vs_udr = 1'b0; cycle();
    overrun_clr = 1'b1; cycle(); overrun_clr = 1'b0;
    chk("ovr_set_wins", 64'(overrun), 64'd1);
    chk("ovr_jdo_kept2", 64'(jdo), 64'h1_2345_6789);
    overrun_clr = 1'b1; cycle(); overrun_clr = 1'b0;
    chk("ovr_cleared", 64'(overrun), 64'd0);
    idle(2);

    // Back-to-back: consume and capture in the same cycle
    sr = 38'h0_0BAD_F00D; ir_in = 2'd3;
    vs_udr = 1'b1; cycle(); vs_udr = 1'b0; cycle();
    cmd_ready = 1'b1; cycle(); cmd_ready = 1'b0;
    chk("b2b_valid", 64'(cmd_valid), 64'd1);
    chk("b2b_jdo", 64'(jdo), 64'h0_0BAD_F00D);
    chk("b2b_tna", 64'(take_no_action), 64'b1000);
    cycle();
    chk("b2b_tna_once", 64'(take_no_action), 64'd0);
    cmd_ready = 1'b1; cycle(); cmd_ready = 1'b0; idle(2);

    // Coincident uir and udr
    sr = 38'h8_0000_0042; ir_in = 2'd1;
    vs_udr = 1'b1; vs_uir = 1'b1; cycle(); vs_udr = 1'b0; vs_uir = 1'b0; idle(2);
    chk("uir_pulse", 64'(uir_seen), 64'd1);
    chk("uir_ta", 64'(take_action), 64'b0010);
    idle(2);

    // Reset while holding a command
    reset = 1'b1; cycle(); reset = 1'b0;
    chk("midrst_valid", 64'(cmd_valid), 64'd0);
    chk("midrst_jdo", 64'(jdo), 64'd0);
    idle(SS + 3);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 99) == 0);
      cmd_ready = ($urandom_range(0, 2) == 0);
      overrun_clr = ($urandom_range(0, 7) == 0);
      vs_uir = ($urandom_range(0, 5) == 0) ? ~vs_uir : vs_uir;
      if (vs_udr) begin
        if ($urandom_range(0, 1) == 0) begin vs_udr = 1'b0; low_cnt = 0; end
      end else begin
        low_cnt++;
        if (low_cnt >= SS + 2 && $urandom_range(0, 2) == 0) begin
          sr = SRW'({$urandom, $urandom});
          ir_in = IRW'($urandom_range(0, NC - 1));
          vs_udr = 1'b1;
        end
      end
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
